// File: rtl/whack_round_ctrl.sv
// Round sequencer for the Whack-a-Mole game.
//
// Owns a 2-digit BCD countdown round timer and a 3-digit BCD score, each built
// from cascaded mod-10 stages, plus a four-state round FSM (idle/run/pause/over).
//
// Parameters:
//   START_TENS, START_ONES  round length in seconds as two BCD digits (01..99)
// Ports:
//   clk                       system clock
//   clr_n                     asynchronous active-low reset
//   tick                      1 Hz enable pulse, decrements the timer in RUN
//   start                     begin a new round (from IDLE or OVER)
//   pause                     toggle RUN/PAUSE
//   hit, miss                 score +1 / -1 in RUN (both together: no change)
//   time_tens, time_ones      BCD timer digits
//   score_hund/tens/ones      BCD score digits
//   running                   high only in RUN, enables the mole generator
//   game_over                 high while in OVER
//   over_pulse                one-cycle pulse on entry to OVER
module whack_round_ctrl #(
  parameter int unsigned START_TENS = 6,
  parameter int unsigned START_ONES = 0
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       tick,
  input  logic       start,
  input  logic       pause,
  input  logic       hit,
  input  logic       miss,
  output logic [3:0] time_tens,
  output logic [3:0] time_ones,
  output logic [3:0] score_hund,
  output logic [3:0] score_tens,
  output logic [3:0] score_ones,
  output logic       running,
  output logic       game_over,
  output logic       over_pulse
);

  localparam logic [3:0] StartTens = 4'(START_TENS);
  localparam logic [3:0] StartOnes = 4'(START_ONES);

  typedef enum logic [1:0] {StIdle, StRun, StPause, StOver} state_e;

  state_e     state_q, state_d;
  logic [3:0] tt_q, tt_d, to_q, to_d;
  logic [3:0] sh_q, sh_d, st_q, st_d, so_q, so_d;
  logic       over_q, over_d;

  logic score_max, score_min, last_tick;

  assign score_max = (sh_q == 4'd9) && (st_q == 4'd9) && (so_q == 4'd9);
  assign score_min = (sh_q == 4'd0) && (st_q == 4'd0) && (so_q == 4'd0);
  assign last_tick = tick && (tt_q == 4'd0) && (to_q == 4'd1);

  always_comb begin
    state_d = state_q;
    tt_d    = tt_q;
    to_d    = to_q;
    sh_d    = sh_q;
    st_d    = st_q;
    so_d    = so_q;
    over_d  = 1'b0;

    unique case (state_q)
      StIdle, StOver: begin
        if (start) begin
          state_d = StRun;
          tt_d    = StartTens;
          to_d    = StartOnes;
          sh_d    = 4'd0;
          st_d    = 4'd0;
          so_d    = 4'd0;
        end
      end

      StRun: begin
        // Score: increment cascade with saturation at 999.
        if (hit && !miss && !score_max) begin
          if (so_q != 4'd9) begin
            so_d = so_q + 4'd1;
          end else begin
            so_d = 4'd0;
            if (st_q != 4'd9) begin
              st_d = st_q + 4'd1;
            end else begin
              st_d = 4'd0;
              sh_d = sh_q + 4'd1;
            end
          end
        end
        // Score: decrement cascade with saturation at 000.
        if (miss && !hit && !score_min) begin
          if (so_q != 4'd0) begin
            so_d = so_q - 4'd1;
          end else begin
            so_d = 4'd9;
            if (st_q != 4'd0) begin
              st_d = st_q - 4'd1;
            end else begin
              st_d = 4'd9;
              sh_d = sh_q - 4'd1;
            end
          end
        end
        // Timer: ones counts down, tens borrows on the 0 -> 9 wrap.
        if (tick) begin
          if (to_q != 4'd0) begin
            to_d = to_q - 4'd1;
          end else begin
            to_d = 4'd9;
            tt_d = tt_q - 4'd1;
          end
        end
        // Ending the round takes priority over a simultaneous pause.
        if (last_tick) begin
          state_d = StOver;
          over_d  = 1'b1;
        end else if (pause) begin
          state_d = StPause;
        end
      end

      StPause: begin
        if (pause) begin
          state_d = StRun;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= StIdle;
      tt_q    <= StartTens;
      to_q    <= StartOnes;
      sh_q    <= 4'd0;
      st_q    <= 4'd0;
      so_q    <= 4'd0;
      over_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tt_q    <= tt_d;
      to_q    <= to_d;
      sh_q    <= sh_d;
      st_q    <= st_d;
      so_q    <= so_d;
      over_q  <= over_d;
    end
  end

  assign time_tens  = tt_q;
  assign time_ones  = to_q;
  assign score_hund = sh_q;
  assign score_tens = st_q;
  assign score_ones = so_q;
  assign running    = (state_q == StRun);
  assign game_over  = (state_q == StOver);
  assign over_pulse = over_q;

endmodule

// File: tb/tb_whack_round_ctrl.sv
// Self-checking bench for whack_round_ctrl: directed scenarios followed by a
// randomized phase, all compared against an integer-valued round/score model.
module tb_whack_round_ctrl;

  localparam int unsigned StartT = 6;
  localparam int unsigned StartO = 0;
  localparam int StartSecs = StartT * 10 + StartO;

  logic       clk = 1'b0;
  logic       clr_n = 1'b1;
  logic       tick = 1'b0, start = 1'b0, pause = 1'b0, hit = 1'b0, miss = 1'b0;
  logic [3:0] time_tens, time_ones, score_hund, score_tens, score_ones;
  logic       running, game_over, over_pulse;

  whack_round_ctrl #(
    .START_TENS(StartT),
    .START_ONES(StartO)
  ) dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .tick      (tick),
    .start     (start),
    .pause     (pause),
    .hit       (hit),
    .miss      (miss),
    .time_tens (time_tens),
    .time_ones (time_ones),
    .score_hund(score_hund),
    .score_tens(score_tens),
    .score_ones(score_ones),
    .running   (running),
    .game_over (game_over),
    .over_pulse(over_pulse)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: 0 idle, 1 run, 2 pause, 3 over; time in seconds, score as integer.
  int m_mode = 0;
  int m_time = StartSecs;
  int m_score = 0;
  bit m_pulse = 1'b0;

  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".time_tens"}, {8'd0, time_tens}, 12'(m_time / 10));
    check({tag, ".time_ones"}, {8'd0, time_ones}, 12'(m_time % 10));
    check({tag, ".score"}, {score_hund, score_tens, score_ones},
          {4'(m_score / 100), 4'((m_score / 10) % 10), 4'(m_score % 10)});
    check({tag, ".flags"}, {9'd0, running, game_over, over_pulse},
          {9'd0, m_mode == 1, m_mode == 3, m_pulse});
  endtask

  task automatic model_reset();
    m_mode  = 0;
    m_time  = StartSecs;
    m_score = 0;
    m_pulse = 1'b0;
  endtask

  task automatic model_edge(input bit t, input bit s, input bit p, input bit h, input bit m);
    m_pulse = 1'b0;
    case (m_mode)
      0, 3: if (s) begin
        m_mode  = 1;
        m_time  = StartSecs;
        m_score = 0;
      end
      1: begin
        if (h && !m && m_score < 999) m_score++;
        if (m && !h && m_score > 0) m_score--;
        if (t) begin
          m_time--;
          if (m_time == 0) begin
            m_mode  = 3;
            m_pulse = 1'b1;
          end
        end
        if (p && m_mode == 1) m_mode = 2;
      end
      2: if (p) m_mode = 1;
      default: ;
    endcase
  endtask

  // One clock cycle with the given input pulses, then a full output compare.
  task automatic step(input string tag, input bit t, input bit s, input bit p, input bit h,
                      input bit m);
    @(negedge clk);
    tick = t; start = s; pause = p; hit = h; miss = m;
    @(posedge clk);
    model_edge(t, s, p, h, m);
    #1;
    check_all(tag);
  endtask

  task automatic idle_cycle(input string tag);
    step(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // Power-on reset.
    #3 clr_n = 1'b0;
    #1 model_reset();
    check_all("reset_async");
    repeat (2) @(posedge clk);
    @(negedge clk) clr_n = 1'b1;
    #1 check_all("reset_hold");
    step("idle_ignores", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);

    // Full round: 60 ticks down to 00, over_pulse on the last edge.
    step("start", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < StartSecs; i++) step("round_tick", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle_cycle("over_pulse_clear");
    step("over_ignores", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);

    // 123 hits interleaved with ticks, 3 misses, hit+miss together.
    step("start2", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 123; i++) step("hits", (i % 5) == 4, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step("misses", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step("hit_and_miss", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step("run_ignores_start", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Saturation at 999, then at 000 in a fresh round.
    for (int i = 0; i < 880; i++) step("sat_hi", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    while (m_mode == 1) step("drain", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("start3", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("miss_at_zero", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Pause at 45: ticks and hits held off, then resume.
    for (int i = 0; i < 15; i++) step("to45", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("pause_on", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step("paused_tick", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) step("paused_hit", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("paused_start", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    step("pause_off", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step("resume_tick", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // At 01: tick+pause ends the round.
    while (m_time > 1) step("to01", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("tick_pause_01", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    // At 01: tick+hit scores and ends the round; then restart from OVER.
    step("start4", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    while (m_time > 1) step("to01b", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("tick_hit_01", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step("start_from_over", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Mid-round asynchronous clear at time 37, score 015.
    for (int i = 0; i < 15; i++) step("score15", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    while (m_time > 37) step("to37", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    tick = 1'b0; start = 1'b0; pause = 1'b0; hit = 1'b0; miss = 1'b0;
    #2 clr_n = 1'b0;
    #1 model_reset();
    check_all("clr_async");
    @(negedge clk) clr_n = 1'b1;
    #1 check_all("clr_release");
    step("start_after_clr", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step("post_clr", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

    // Randomized phase against the model.
    for (int i = 0; i < 4000; i++) begin
      step("random",
           $urandom_range(0, 2) == 0,
           $urandom_range(0, 39) == 0,
           $urandom_range(0, 24) == 0,
           $urandom_range(0, 2) == 0,
           $urandom_range(0, 3) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
